// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 serial receiver with a two-flop line synchronizer,
// mid-bit start validation and data sampling, stop-bit checking, a
// valid/ack output handshake, a sticky overrun flag and a framing-error pulse.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          s1_r;
    logic          rx_s;

    // Two-flop synchronizer bringing the asynchronous line into the clk domain; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1_r <= rx;
            rx_s <= s1_r;
        end
    end

    // Frame FSM with bit timing, shift register and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // An ack retires the held byte; overrun can only be set while a byte is held.
            if (data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                data_valid <= data_valid;
                overrun    <= overrun;
            end
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r <= START;
                        cnt_r   <= CNT_ZERO;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == HALF_LAST) begin
                        if (!rx_s) begin
                            state_r   <= DATA;
                            cnt_r     <= CNT_ZERO;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: treat as a glitch.
                            state_r <= IDLE;
                            cnt_r   <= CNT_ZERO;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == FULL_LAST) begin
                        shift_r[bit_idx_r] <= rx_s;
                        cnt_r              <= CNT_ZERO;
                        bit_idx_r          <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s) begin
                            // Good stop: the new byte always wins, even over a same-edge ack.
                            data_out   <= shift_r;
                            data_valid <= 1'b1;
                            overrun    <= data_valid & ~data_ack;
                            state_r    <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_r   <= BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                BREAK: begin
                    // Hold off until the line idles so a stuck-low line yields no phantom frames.
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= BREAK;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed self-checking bench for uart_rx_sampler at 16 clocks per bit.
module tb_uart_rx_sampler;

    localparam int C = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_cmp;
    int n_err;

    uart_rx_sampler #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case any handshake never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame; the posedge where rx falls is E0. Next call starts with no idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (C) @(posedge clk);
        #1 rx = stop_lvl;
        repeat (C - 1) @(posedge clk);
    endtask

    // Wait (bounded) for data_valid at a negedge.
    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (data_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One-cycle ack pulse launched from a negedge.
    task automatic pulse_ack;
        data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
    endtask

    logic [7:0] got_q [$];
    logic       ok;
    int         ov_seen;
    int         fe_cnt;
    int         v_cnt;
    int         b_cnt;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        rx       = 1'b1;
        data_ack = 1'b0;

        // Reset state
        #1;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // Single byte 0x83: valid appears right after E0+155
        fork
            send_frame(8'h83, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                check("single_valid_early", 32'(data_valid), 32'h0);
                check("single_busy_mid", 32'(busy), 32'h1);
                @(posedge clk);
                #1;
                check("single_valid", 32'(data_valid), 32'h1);
                check("single_data", 32'(data_out), 32'h83);
                check("single_ferr", 32'(frame_err), 32'h0);
                check("single_busy_end", 32'(busy), 32'h0);
                data_ack = 1'b1;
                @(posedge clk);
                #1 data_ack = 1'b0;
                check("single_ack_clear", 32'(data_valid), 32'h0);
            end
        join

        // Back-to-back 0x07, 0xF0 with immediate acks
        ov_seen = 0;
        fork
            begin
                send_frame(8'h07, 1'b1);
                send_frame(8'hF0, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_valid(ok);
                    check("b2b_timeout", 32'(ok), 32'h1);
                    got_q.push_back(data_out);
                    if (overrun) ov_seen++;
                    pulse_ack();
                end
            end
        join
        check("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_byte0", 32'(got_q[0]), 32'h07);
            check("b2b_byte1", 32'(got_q[1]), 32'hF0);
        end
        check("b2b_overrun", 32'(ov_seen), 32'd0);

        // Overrun: 0xAA then 0x55, no ack
        send_frame(8'hAA, 1'b1);
        send_frame(8'h55, 1'b1);
        @(negedge clk);
        check("ovr_data", 32'(data_out), 32'h55);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_valid", 32'(data_valid), 32'h1);
        pulse_ack();
        @(negedge clk);
        check("ovr_ack_valid", 32'(data_valid), 32'h0);
        check("ovr_ack_flag", 32'(overrun), 32'h0);

        // Framing error 0x3C with low stop, line then held low for 40 cycles
        fe_cnt = 0;
        v_cnt  = 0;
        fork
            begin
                send_frame(8'h3C, 1'b0);
                repeat (40) @(posedge clk);
            end
            begin
                for (int i = 0; i < 195; i++) begin
                    @(negedge clk);
                    if (frame_err) fe_cnt++;
                    if (data_valid) v_cnt++;
                end
            end
        join
        check("fe_pulses", 32'(fe_cnt), 32'd1);
        check("fe_valid", 32'(v_cnt), 32'd0);
        @(negedge clk);
        check("fe_break_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("fe_break_exit", 32'(busy), 32'h0);
        send_frame(8'h11, 1'b1);
        wait_valid(ok);
        check("fe_next_timeout", 32'(ok), 32'h1);
        check("fe_next_data", 32'(data_out), 32'h11);
        pulse_ack();

        // Glitch: 4-cycle low pulse, busy for exactly C/2 cycles
        repeat (5) @(posedge clk);
        b_cnt  = 0;
        v_cnt  = 0;
        fe_cnt = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 rx = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (busy) b_cnt++;
                    if (data_valid) v_cnt++;
                    if (frame_err) fe_cnt++;
                end
            end
        join
        check("glitch_busy_cycles", 32'(b_cnt), 32'd8);
        check("glitch_valid", 32'(v_cnt), 32'd0);
        check("glitch_ferr", 32'(fe_cnt), 32'd0);

        // Asynchronous reset mid-frame with a byte pending
        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        check("pre_rst_valid", 32'(data_valid), 32'h1);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #3 rst = 1'b0;
                #1;
                check("mid_rst_data", 32'(data_out), 32'h00);
                check("mid_rst_valid", 32'(data_valid), 32'h0);
                check("mid_rst_overrun", 32'(overrun), 32'h0);
                check("mid_rst_ferr", 32'(frame_err), 32'h0);
                check("mid_rst_busy", 32'(busy), 32'h0);
            end
        join
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_valid", 32'(data_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
